// File: rtl/ripple_down_counter.sv
// Asynchronous ripple down-counter: a chain of toggle flip-flops where each
// stage is clocked by the rising edge of the stage below it.

module ripple_tff_stage (
  input  logic clk_i,
  input  logic clr_n_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // T is tied high, so every clock edge toggles the stage
  always_comb begin
    q_d = ~q_q;
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

module ripple_down_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] stage_clk;

  // A rising Q on stage i-1 means it wrapped 0->1, i.e. a borrow into stage i
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
    if (i == 0) begin : g_lsb
      assign stage_clk[i] = clk;
    end else begin : g_upper
      assign stage_clk[i] = stage_q[i-1];
    end

    ripple_tff_stage u_stage (
      .clk_i   (stage_clk[i]),
      .clr_n_i (reset),
      .q_o     (stage_q[i])
    );
  end

  assign out = stage_q;

endmodule

// File: tb/tb_ripple_down_counter.sv
// Directed bench for ripple_down_counter: WIDTH=3 sequence, wrap, async reset
// mid-count, reset held across edges, and a WIDTH=4 full cycle.

module tb_ripple_down_counter;

  logic       clk;
  logic       rst3_n;
  logic       rst4_n;
  logic [2:0] out3;
  logic [3:0] out4;

  int n_checks;
  int n_errors;

  ripple_down_counter #(.WIDTH(3)) u_dut3 (
    .clk   (clk),
    .reset (rst3_n),
    .out   (out3)
  );

  ripple_down_counter #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .reset (rst4_n),
    .out   (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [2:0] seq3 [8];
  logic [3:0] exp4;

  initial begin
    n_checks = 0;
    n_errors = 0;
    seq3[0] = 3'b111; seq3[1] = 3'b110; seq3[2] = 3'b101; seq3[3] = 3'b100;
    seq3[4] = 3'b011; seq3[5] = 3'b010; seq3[6] = 3'b001; seq3[7] = 3'b000;

    // Reset held across a clk rising edge
    rst3_n = 1'b0;
    rst4_n = 1'b0;
    #1;
    check("rst_hold_pre", 32'(out3), 32'd0);
    @(negedge clk);
    check("rst_hold_post_edge", 32'(out3), 32'd0);

    // Release between edges: no change until the next rising edge
    rst3_n = 1'b1;
    #1;
    check("rst_release", 32'(out3), 32'd0);

    // 20 edges: sequence repeats with period 8, wrapping 000 -> 111
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("seq_edge%0d", i), 32'(out3), 32'(seq3[i % 8]));
    end

    // From 100, seven more edges reach 101
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
    end
    #1;
    check("pre_midreset", 32'(out3), 32'b101);

    // Async assertion mid-cycle clears with no clock edge
    #2;
    rst3_n = 1'b0;
    #1;
    check("midreset_clear", 32'(out3), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    #1;
    check("midreset_release", 32'(out3), 32'd0);
    @(posedge clk);
    #1;
    check("midreset_first_edge", 32'(out3), 32'b111);

    // Reset held low while clock keeps running
    @(negedge clk);
    rst3_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_clk_edge%0d", i), 32'(out3), 32'd0);
    end
    @(negedge clk);
    rst3_n = 1'b1;

    // WIDTH=4: one full cycle of 16 decrements
    check("w4_reset", 32'(out4), 32'd0);
    rst4_n = 1'b1;
    exp4 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      exp4 = exp4 - 4'd1;
      @(posedge clk);
      #1;
      check($sformatf("w4_edge%0d", i), 32'(out4), 32'(exp4));
    end
    check("w4_final_zero", 32'(out4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
